// File: rtl/cpu_control_unit.sv
// SM83 microcoded control unit: sequences 4-T-cycle M-cycles and drives datapath controls.
// Optional CPU_CONTROL_JP_HL_EN enables single-M-cycle JP HL (E9); otherwise E9 decodes as NOP.
module cpu_control_unit (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] t_cycle,
   input  logic [7:0] mem_data_in,
   input  logic       condition,
   output logic [1:0] pc_next,
   output logic       inst_load,
   output logic [3:0] reg_read1_sel,
   output logic [3:0] reg_read2_sel,
   output logic [3:0] reg_write_sel,
   output logic [2:0] reg_op,
   output logic [1:0] alu_op,
   output logic       alu_sel_a,
   output logic       alu_sel_b,
   output logic       alu_write_flags,
   output logic       mem_enable,
   output logic       mem_write,
   output logic [1:0] mem_addr_sel
);

   typedef enum logic [1:0] {STEP0, STEP1, STEP2, STEP3} step_t;
   typedef enum logic [1:0] {PC_SAME, PC_INC, PC_REG, PC_REGINC} pc_next_t;
   typedef enum logic [3:0] {
      SEL_A, SEL_C, SEL_W, SEL_Z, SEL_SRC, SEL_DST, SEL_HL, SEL_R16HI, SEL_R16LO
   } sel_t;
   typedef enum logic [2:0] {OP_NONE, OP_WALU, OP_WMEM, OP_INCHL, OP_DECHL} reg_op_t;
   typedef enum logic [1:0] {ALU_COPYA, ALU_COPYB, ALU_INCA, ALU_INST} alu_op_t;
   typedef enum logic [1:0] {ADDR_PC, ADDR_HL, ADDR_REG, ADDR_HIGH} addr_t;

   logic [7:0] opcode;
   step_t      step;
   logic       fetch;

   always_ff @(posedge clk) begin
      if (reset) begin
         opcode <= '0;
         step   <= STEP0;
      end else if (t_cycle == 2'd3) begin
         if (inst_load) begin
            opcode <= mem_data_in;
            step   <= STEP0;
         end else begin
            step <= step.next();
         end
      end
   end

   always_comb begin
      fetch           = 1'b0;
      pc_next         = PC_SAME;
      inst_load       = 1'b0;
      reg_read1_sel   = '0;
      reg_read2_sel   = '0;
      reg_write_sel   = '0;
      reg_op          = OP_NONE;
      alu_op          = ALU_COPYA;
      alu_sel_a       = 1'b0;
      alu_sel_b       = 1'b0;
      alu_write_flags = 1'b0;
      mem_enable      = 1'b0;
      mem_write       = 1'b0;
      mem_addr_sel    = ADDR_PC;

      // Wildcard groups are decoded as an if-chain so the more specific encodings win.
      if (opcode == 8'h76) begin
         fetch = 1'b1;
      end else if (opcode[7:6] == 2'b01) begin
         if (opcode[5:3] == 3'd6) begin
            if (step == STEP0) begin
               mem_enable = 1'b1; mem_write = 1'b1; mem_addr_sel = ADDR_HL;
               reg_read2_sel = SEL_SRC; alu_op = ALU_COPYB;
            end else fetch = 1'b1;
         end else if (opcode[2:0] == 3'd6) begin
            if (step == STEP0) begin
               mem_enable = 1'b1; mem_addr_sel = ADDR_HL;
               reg_op = OP_WMEM; reg_write_sel = SEL_DST;
            end else fetch = 1'b1;
         end else begin
            fetch = 1'b1;
            reg_read2_sel = SEL_SRC; alu_op = ALU_COPYB;
            reg_write_sel = SEL_DST; reg_op = OP_WALU;
         end
      end else if (opcode[7:6] == 2'b10 || (opcode[7:6] == 2'b11 && opcode[2:0] == 3'd6)) begin
         if (opcode[7:6] == 2'b10 && opcode[2:0] != 3'd6) begin
            fetch = 1'b1;
            reg_read2_sel = SEL_SRC; alu_op = ALU_INST;
            reg_write_sel = SEL_A; reg_op = OP_WALU; alu_write_flags = 1'b1;
         end else if (step == STEP0) begin
            mem_enable = 1'b1; reg_op = OP_WMEM; reg_write_sel = SEL_Z;
            if (opcode[6]) pc_next = PC_INC;
            else mem_addr_sel = ADDR_HL;
         end else begin
            fetch = 1'b1;
            reg_read2_sel = SEL_Z; alu_op = ALU_INST;
            reg_write_sel = SEL_A; reg_op = OP_WALU; alu_write_flags = 1'b1;
         end
      end else if (opcode == 8'h36) begin
         if (step == STEP0) begin
            mem_enable = 1'b1; pc_next = PC_INC; reg_op = OP_WMEM; reg_write_sel = SEL_Z;
         end else if (step == STEP1) begin
            mem_enable = 1'b1; mem_write = 1'b1; mem_addr_sel = ADDR_HL;
            reg_read2_sel = SEL_Z; alu_op = ALU_COPYB;
         end else fetch = 1'b1;
      end else if (opcode[7:6] == 2'b00 && opcode[2:0] == 3'd6) begin
         if (step == STEP0) begin
            mem_enable = 1'b1; pc_next = PC_INC; reg_op = OP_WMEM; reg_write_sel = SEL_DST;
         end else fetch = 1'b1;
      end else if (opcode[7:6] == 2'b00 && opcode[3:0] == 4'h1) begin
         if (step == STEP0 || step == STEP1) begin
            mem_enable = 1'b1; pc_next = PC_INC; reg_op = OP_WMEM;
            reg_write_sel = (step == STEP0) ? SEL_R16LO : SEL_R16HI;
         end else fetch = 1'b1;
      end else begin
         case (opcode)
            8'h0A, 8'h1A, 8'h02, 8'h12: begin
               if (step == STEP0) begin
                  mem_enable = 1'b1; mem_addr_sel = ADDR_REG;
                  reg_read1_sel = SEL_R16HI; reg_read2_sel = SEL_R16LO;
                  if (opcode[3]) begin
                     reg_op = OP_WMEM; reg_write_sel = SEL_A;
                  end else mem_write = 1'b1;
               end else fetch = 1'b1;
            end
            8'h22, 8'h32: begin
               if (step == STEP0) begin
                  mem_enable = 1'b1; mem_write = 1'b1; mem_addr_sel = ADDR_HL;
                  reg_op = opcode[4] ? OP_DECHL : OP_INCHL;
               end else fetch = 1'b1;
            end
            8'h2A, 8'h3A: begin
               if (step == STEP0) begin
                  mem_enable = 1'b1; mem_addr_sel = ADDR_HL;
                  reg_op = OP_WMEM; reg_write_sel = SEL_A;
               end else begin
                  fetch = 1'b1;
                  reg_op = opcode[4] ? OP_DECHL : OP_INCHL;
               end
            end
            8'hE0, 8'hF0: begin
               if (step == STEP0) begin
                  mem_enable = 1'b1; pc_next = PC_INC; reg_op = OP_WMEM; reg_write_sel = SEL_Z;
               end else if (step == STEP1) begin
                  mem_enable = 1'b1; mem_addr_sel = ADDR_HIGH; reg_read2_sel = SEL_Z;
                  if (opcode[4]) begin
                     reg_op = OP_WMEM; reg_write_sel = SEL_A;
                  end else mem_write = 1'b1;
               end else fetch = 1'b1;
            end
            8'hE2, 8'hF2: begin
               if (step == STEP0) begin
                  mem_enable = 1'b1; mem_addr_sel = ADDR_HIGH; reg_read2_sel = SEL_C;
                  if (opcode[4]) begin
                     reg_op = OP_WMEM; reg_write_sel = SEL_A;
                  end else mem_write = 1'b1;
               end else fetch = 1'b1;
            end
            8'hC3, 8'hC2, 8'hCA, 8'hD2, 8'hDA: begin
               // opcode[0] is set only for the unconditional C3.
               if (step == STEP0 || step == STEP1) begin
                  mem_enable = 1'b1; pc_next = PC_INC; reg_op = OP_WMEM;
                  reg_write_sel = (step == STEP0) ? SEL_Z : SEL_W;
               end else if (step == STEP2 && (opcode[0] || condition)) begin
                  pc_next = PC_REG; reg_read1_sel = SEL_W; reg_read2_sel = SEL_Z;
               end else fetch = 1'b1;
            end
`ifdef CPU_CONTROL_JP_HL_EN
            8'hE9: begin
               mem_enable = 1'b1; mem_addr_sel = ADDR_HL; pc_next = PC_REGINC;
               reg_read1_sel = SEL_HL; reg_read2_sel = SEL_HL; inst_load = 1'b1;
            end
`endif
            default: fetch = 1'b1;
         endcase
      end

      if (fetch) begin
         mem_enable   = 1'b1;
         mem_write    = 1'b0;
         mem_addr_sel = ADDR_PC;
         pc_next      = PC_INC;
         inst_load    = 1'b1;
      end
   end

endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed scoreboard bench for cpu_control_unit: one expected control word per M-cycle.
module tb_cpu_control_unit;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] t_cycle;
   logic [7:0] mem_data_in;
   logic       condition;
   logic [1:0] pc_next;
   logic       inst_load;
   logic [3:0] reg_read1_sel, reg_read2_sel, reg_write_sel;
   logic [2:0] reg_op;
   logic [1:0] alu_op;
   logic       alu_sel_a, alu_sel_b, alu_write_flags;
   logic       mem_enable, mem_write;
   logic [1:0] mem_addr_sel;

   typedef struct packed {
      logic [1:0] pcn;
      logic       il;
      logic [3:0] r1;
      logic [3:0] r2;
      logic [3:0] ws;
      logic [2:0] op;
      logic [1:0] alu;
      logic       sa;
      logic       sb;
      logic       fl;
      logic       men;
      logic       mwr;
      logic [1:0] addr;
   } ctl_t;

   ctl_t  obs;
   ctl_t  e;
   ctl_t  exp_q[$];
   string tag_q[$];
   int unsigned total = 0;
   int unsigned bad = 0;

   cpu_control_unit dut (
      .clk(clk), .reset(reset), .t_cycle(t_cycle), .mem_data_in(mem_data_in),
      .condition(condition), .pc_next(pc_next), .inst_load(inst_load),
      .reg_read1_sel(reg_read1_sel), .reg_read2_sel(reg_read2_sel),
      .reg_write_sel(reg_write_sel), .reg_op(reg_op), .alu_op(alu_op),
      .alu_sel_a(alu_sel_a), .alu_sel_b(alu_sel_b), .alu_write_flags(alu_write_flags),
      .mem_enable(mem_enable), .mem_write(mem_write), .mem_addr_sel(mem_addr_sel)
   );

   always #5 clk = ~clk;

   assign obs = {pc_next, inst_load, reg_read1_sel, reg_read2_sel, reg_write_sel, reg_op,
                 alu_op, alu_sel_a, alu_sel_b, alu_write_flags, mem_enable, mem_write,
                 mem_addr_sel};

   function automatic ctl_t k_fetch();
      ctl_t c = '0;
      c.men = 1'b1; c.pcn = 2'd1; c.il = 1'b1;
      return c;
   endfunction

   // RD(Pc) with PC increment, written into register select ws.
   function automatic ctl_t k_pcrd(input logic [3:0] ws);
      ctl_t c = '0;
      c.men = 1'b1; c.pcn = 2'd1; c.op = 3'd2; c.ws = ws;
      return c;
   endfunction

   task automatic push(input string tag, input ctl_t x);
      exp_q.push_back(x);
      tag_q.push_back(tag);
   endtask

   task automatic check();
      ctl_t  x;
      string tag;
      total++;
      if (exp_q.size() == 0) begin
         bad++;
         $error("FAIL scoreboard_empty observed=%h expected=<entry>", obs);
      end else begin
         x   = exp_q.pop_front();
         tag = tag_q.pop_front();
         assert (obs === x) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, x);
         end
      end
   endtask

   // One M-cycle; outputs compared mid-cycle, reset optionally asserted only at the commit edge.
   task automatic mcycle(input logic [7:0] d, input logic c, input logic rst);
      for (int t = 0; t < 4; t++) begin
         @(negedge clk);
         t_cycle     = 2'(t);
         mem_data_in = d;
         condition   = c;
         reset       = (t == 3) ? rst : 1'b0;
         if (t == 1) begin
            #1;
            check();
         end
      end
   endtask

   task automatic stall(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         t_cycle     = 2'(i % 3);
         mem_data_in = 8'hFF;
         condition   = 1'b1;
      end
   endtask

   initial begin
      reset = 1'b1; t_cycle = 2'd0; mem_data_in = 8'h00; condition = 1'b0;
      repeat (2) @(negedge clk);

      push("reset_fetch", k_fetch()); mcycle(8'h00, 1'b0, 1'b1);
      push("nop_fetch0", k_fetch());  mcycle(8'h00, 1'b0, 1'b0);
      push("nop_fetch1", k_fetch());  mcycle(8'h00, 1'b1, 1'b0);
      push("nop_fetch2", k_fetch());  mcycle(8'h3E, 1'b0, 1'b0);

      push("ldrn_s0", k_pcrd(4'd5)); mcycle(8'h55, 1'b0, 1'b0);
      push("ldrn_s1", k_fetch());    mcycle(8'h42, 1'b0, 1'b0);
      e = k_fetch(); e.r2 = 4'd4; e.alu = 2'd1; e.ws = 4'd5; e.op = 3'd1;
      push("ldrr", e);               mcycle(8'h86, 1'b0, 1'b0);

      stall(5);
      e = '0; e.men = 1'b1; e.addr = 2'd1; e.op = 3'd2; e.ws = 4'd3;
      push("aluhl_s0", e);           mcycle(8'h12, 1'b0, 1'b0);
      e = k_fetch(); e.r2 = 4'd3; e.alu = 2'd3; e.ws = 4'd0; e.op = 3'd1; e.fl = 1'b1;
      push("aluhl_s1", e);           mcycle(8'hC3, 1'b0, 1'b0);

      push("jp_s0", k_pcrd(4'd3));   mcycle(8'h34, 1'b0, 1'b0);
      push("jp_s1", k_pcrd(4'd2));   mcycle(8'h12, 1'b0, 1'b0);
      e = '0; e.pcn = 2'd2; e.r1 = 4'd2; e.r2 = 4'd3;
      push("jp_s2", e);              mcycle(8'h00, 1'b0, 1'b0);
      push("jp_s3", k_fetch());      mcycle(8'hCA, 1'b0, 1'b0);

      push("jpc0_s0", k_pcrd(4'd3)); mcycle(8'h00, 1'b1, 1'b0);
      push("jpc0_s1", k_pcrd(4'd2)); mcycle(8'h10, 1'b1, 1'b0);
      push("jpc0_s2", k_fetch());    mcycle(8'hCA, 1'b0, 1'b0);
      push("jpc1_s0", k_pcrd(4'd3)); mcycle(8'h00, 1'b0, 1'b0);
      push("jpc1_s1", k_pcrd(4'd2)); mcycle(8'h20, 1'b0, 1'b0);
      e = '0; e.pcn = 2'd2; e.r1 = 4'd2; e.r2 = 4'd3;
      push("jpc1_s2", e);            mcycle(8'h00, 1'b1, 1'b0);
      push("jpc1_s3", k_fetch());    mcycle(8'h70, 1'b0, 1'b0);

      e = '0; e.men = 1'b1; e.mwr = 1'b1; e.addr = 2'd1; e.r2 = 4'd4; e.alu = 2'd1;
      push("sthl_s0", e);            mcycle(8'h00, 1'b0, 1'b0);
      push("sthl_s1", k_fetch());    mcycle(8'hE0, 1'b0, 1'b0);

      push("ldh_s0", k_pcrd(4'd3));  mcycle(8'h80, 1'b0, 1'b0);
      e = '0; e.men = 1'b1; e.mwr = 1'b1; e.addr = 2'd3; e.r2 = 4'd3;
      push("ldh_s1", e);             mcycle(8'h00, 1'b0, 1'b0);
      push("ldh_s2", k_fetch());     mcycle(8'hE9, 1'b0, 1'b0);

`ifdef CPU_CONTROL_JP_HL_EN
      e = '0; e.men = 1'b1; e.addr = 2'd1; e.pcn = 2'd3; e.r1 = 4'd6; e.r2 = 4'd6; e.il = 1'b1;
`else
      e = k_fetch();
`endif
      push("jphl", e);               mcycle(8'h2A, 1'b0, 1'b0);

      e = '0; e.men = 1'b1; e.addr = 2'd1; e.op = 3'd2; e.ws = 4'd0;
      push("ldhli_s0", e);           mcycle(8'h00, 1'b0, 1'b0);
      e = k_fetch(); e.op = 3'd3;
      push("ldhli_s1", e);           mcycle(8'h2A, 1'b0, 1'b0);

      e = '0; e.men = 1'b1; e.addr = 2'd1; e.op = 3'd2; e.ws = 4'd0;
      push("ldhli_rst_s0", e);       mcycle(8'h2A, 1'b0, 1'b1);
      push("after_reset", k_fetch()); mcycle(8'h00, 1'b0, 1'b0);
      push("final_fetch", k_fetch()); mcycle(8'h00, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
